shift_add_multiplier: RTL and testbench

- Sequential unsigned WIDTH x WIDTH multiplier built around one WIDTH-bit ripple add stage.
- Sits directly downstream of the ripple adder: it feeds operands to the add stage every cycle and consumes the sum and carry.
- Operands are accepted and results delivered over valid/ready handshakes.
- One partial product is added per clock. A new operation is accepted only while idle.

---
 rtl/shift_add_multiplier_pkg.sv | 13 +
 rtl/full_adder.sv | 14 +
 rtl/ripple_add_stage.sv | 32 +++
 rtl/shift_add_multiplier.sv | 151 +++++++++++++++
 tb/tb_shift_add_multiplier.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default arithmetic width.
package shift_add_multiplier_pkg;

    localparam int unsigned ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
// Ports: a_i, b_i, ci_i - addend bits and carry in; s_o - sum; co_o - carry out.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/ripple_add_stage.sv
// Combinational WIDTH-bit ripple-carry adder built from full_adder cells,
// carry in tied low.
// Ports: a_i, b_i - addends; sum_o - WIDTH-bit sum; carry_out_o - final carry.
module ripple_add_stage
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_out_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    // One full adder per bit, carry rippling LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a_i  (a_i[i]),
            .b_i  (b_i[i]),
            .ci_i (carry[i]),
            .s_o  (sum_o[i]),
            .co_o (carry[i+1])
        );
    end

    assign carry_out_o = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one partial product is added
// per clock through a single ripple add stage, operands and product move over
// valid/ready handshakes.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid/in_ready, a, b - operand handshake (accepted only while idle)
//   out_valid/out_ready, product - result handshake (product = a*b)
//   busy                  - high while computing or holding a result
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
    localparam int unsigned PROD_W = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PROD_W-1:0]  product_q, product_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cy;
    logic               last_step;
    logic               accept;

    assign accept    = (state_q == S_IDLE) && in_valid;
    assign last_step = (count_q == CNT_W'(WIDTH - 1));
    assign addend    = acc_lo_q[0] ? mcand_q : '0;

    // Shared add stage: acc_hi plus the current partial product.
    ripple_add_stage #(
        .WIDTH (WIDTH)
    ) u_add (
        .a_i         (acc_hi_q),
        .b_i         (addend),
        .sum_o       (add_sum),
        .carry_out_o (add_cy)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Handshake/status outputs, decoded from the next state so they register
    // in step with the state.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            S_IDLE:  in_ready_d = 1'b1;
            S_RUN:   busy_d     = 1'b1;
            S_DONE:  begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: in_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Datapath: load on accept, then shift {cy, sum, acc_lo} right each step.
    always_comb begin
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        count_d   = count_q;
        product_d = product_q;
        if (accept) begin
            mcand_d  = a;
            acc_hi_d = '0;
            acc_lo_d = b;
            count_d  = '0;
        end else if (state_q == S_RUN) begin
            {acc_hi_d, acc_lo_d} = {add_cy, add_sum, acc_lo_q[WIDTH-1:1]};
            count_d              = count_q + CNT_W'(1);
            // Capture the finished product so it stays put after the handshake.
            if (last_step) begin
                product_d = {add_cy, add_sum, acc_lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=8): directed vectors,
// backpressure, back-to-back, mid-operation reset and randomized operands
// checked against a plain-arithmetic reference.
module tb_shift_add_multiplier;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;

    int checks = 0;
    int passed = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [PW-1:0] r;
        r = PW'(x) * PW'(y);
        return r;
    endfunction

    // Present an operand pair while idle; returns #1 after the accepting edge
    // with in_valid dropped and a/b scrambled.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    // Count edges until out_valid rises (bounded).
    task automatic wait_done(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 4 * W) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b expected 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else passed++;
        checks++; if (product !== '0) $display("FAIL reset_product got %h expected 0000", product); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int edges;
        out_ready = 1'b1;
        start_op(8'h02, 8'h02);
        wait_done(edges);
        // Accept cycle counts as cycle 0; out_valid appears in cycle W+1.
        checks++; if (edges + 1 !== W + 1) $display("FAIL basic_latency got %0d expected %0d", edges + 1, W + 1); else passed++;
        checks++; if (product !== 16'h0004) $display("FAIL basic_product got %h expected 0004", product); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy_done got %b expected 1", busy); else passed++;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_one_cycle got %b expected 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_idle_ready got %b expected 1", in_ready); else passed++;
        checks++; if (product !== 16'h0004) $display("FAIL basic_retain got %h expected 0004", product); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_vectors();
        logic [W-1:0]  va [4] = '{8'h92, 8'hFF, 8'h00, 8'h5A};
        logic [W-1:0]  vb [4] = '{8'hAB, 8'hFF, 8'h5A, 8'h00};
        logic [PW-1:0] vp [4] = '{16'h6186, 16'hFE01, 16'h0000, 16'h0000};
        int edges;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i]);
            wait_done(edges);
            checks++; if (edges !== W) $display("FAIL vec%0d_latency got %0d expected %0d", i, edges + 1, W + 1); else passed++;
            checks++; if (product !== vp[i]) $display("FAIL vec%0d_product got %h expected %h", i, product, vp[i]); else passed++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int edges;
        out_ready = 1'b0;
        start_op(8'h0D, 8'h0B);
        // Pulses during RUN must be ignored.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_run_ready%0d got %b expected 0", i, in_ready); else passed++;
        end
        in_valid = 1'b0;
        wait_done(edges);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            checks++; if (out_valid !== 1'b1 || product !== 16'h008F || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d got v=%b p=%h r=%b expected v=1 p=008f r=0", i, out_valid, product, in_ready);
            else passed++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || product !== 16'h008F) $display("FAIL bp_hold_end got v=%b p=%h expected v=1 p=008f", out_valid, product); else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got v=%b r=%b expected v=0 r=1", out_valid, in_ready); else passed++;
        checks++; if (product !== 16'h008F) $display("FAIL bp_retain got %h expected 008f", product); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x1, y1, x2, y2;
        int edges;
        x1 = W'($urandom); y1 = W'($urandom);
        x2 = W'($urandom); y2 = W'($urandom);
        out_ready = 1'b1;
        start_op(x1, y1);
        wait_done(edges);
        checks++; if (product !== ref_mul(x1, y1)) $display("FAIL b2b_first got %h expected %h", product, ref_mul(x1, y1)); else passed++;
        // Queue the next pair while still in DONE.
        in_valid = 1'b1; a = x2; b = y2;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_idle got r=%b busy=%b expected r=1 busy=0", in_ready, busy); else passed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL b2b_accept got busy=%b r=%b expected busy=1 r=0", busy, in_ready); else passed++;
        wait_done(edges);
        checks++; if (edges !== W) $display("FAIL b2b_latency got %0d expected %0d", edges + 1, W + 1); else passed++;
        checks++; if (product !== ref_mul(x2, y2)) $display("FAIL b2b_second got %h expected %h", product, ref_mul(x2, y2)); else passed++;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int edges;
        out_ready = 1'b1;
        start_op(8'hC7, 8'h9E);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || product !== '0 || in_ready !== 1'b1)
            $display("FAIL midreset got v=%b busy=%b p=%h r=%b expected v=0 busy=0 p=0000 r=1", out_valid, busy, product, in_ready);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        start_op(8'h03, 8'h07);
        wait_done(edges);
        checks++; if (edges !== W) $display("FAIL midreset_latency got %0d expected %0d", edges + 1, W + 1); else passed++;
        checks++; if (product !== 16'h0015) $display("FAIL midreset_product got %h expected 0015", product); else passed++;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0]  x, y;
        logic [PW-1:0] exp_p;
        int edges, hold;
        for (int n = 0; n < 25; n++) begin
            x = W'($urandom);
            y = W'($urandom);
            exp_p = ref_mul(x, y);
            out_ready = 1'b0;
            start_op(x, y);
            wait_done(edges);
            checks++; if (edges !== W) $display("FAIL rnd%0d_latency got %0d expected %0d", n, edges + 1, W + 1); else passed++;
            checks++; if (product !== exp_p) $display("FAIL rnd%0d_product a=%h b=%h got %h expected %h", n, x, y, product, exp_p); else passed++;
            hold = int'($urandom_range(0, 3));
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            checks++; if (out_valid !== 1'b1 || product !== exp_p) $display("FAIL rnd%0d_hold got v=%b p=%h expected v=1 p=%h", n, out_valid, product, exp_p); else passed++;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            checks++; if (in_ready !== 1'b1) $display("FAIL rnd%0d_return got %b expected 1", n, in_ready); else passed++;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
